lr35902_dma: RTL
================

# lr35902_dma

OAM DMA controller for the LR35902 system: owns the DMA source register at FF46 and sequences the 160-byte copy from `{src,8'h00}` into OAM `FE00–FE9F`. It drives the DMA read address and strobes into the shared memory map and the OAM write port, and it raises `active` so the top level reroutes OAM and blocks CPU access. It runs on the Game Boy core clock alongside the CPU, divider and boot ROM blocks.

## Interface
Parameters:
- `CYCLES_PER_BYTE`, default 4 — clk cycles per transferred byte (one M-cycle); legal range is 2 or more.
- `OAM_BYTES`, default 160 — number of bytes per transfer.

Ports:
- `clk` in 1 — core clock (gbclk); all state updates on its rising edge.
- `n_reset` in 1 — asynchronous, active-low reset.
- `din_reg` in 8 — CPU write data for FF46.
- `write_reg` in 1 — FF46 write strobe, already qualified with `cs_io_dma`.
- `dout_reg` out 8 — FF46 readback, the last value written.
- `adr_rd` out 16 — DMA source address `{src, idx}`.
- `rd` out 1 — DMA read strobe.
- `din` in 8 — DMA read data from the source mux (combinational, valid while `rd`).
- `adr_wr` out 8 — OAM byte index.
- `wr` out 1 — OAM write strobe.
- `dout` out 8 — OAM write data.
- `active` out 1 — DMA owns OAM and the source bus.

## Operation
- Reset values: `dout_reg`=8'h00, `adr_rd`=16'h0000, `rd`=0, `adr_wr`=8'h00, `wr`=0, `dout`=8'h00, `active`=0. State goes to IDLE, `idx`=0, `phase`=0.
- Sampling `write_reg`=1 at an edge does all of the following:
  - `src <= din_reg`, `dout_reg <= din_reg`, `idx <= 0`, `phase <= 0`.
  - State goes to START from any state, so a write during START or XFER restarts the transfer.
- States:
  - IDLE — `active`=0, strobes low.
  - START — `active`=1, lasts `CYCLES_PER_BYTE` cycles with no bus strobes (setup slot). At `phase`=`CYCLES_PER_BYTE`-1 it moves to XFER with `phase`=0.
  - XFER — one slot per byte, with `phase` running 0..`CYCLES_PER_BYTE`-1:
    - Phases 0..`CYCLES_PER_BYTE`-2: `rd`=1, `adr_rd`={src,idx}. The latch captures `din` at the edge ending phase `CYCLES_PER_BYTE`-2.
    - Phase `CYCLES_PER_BYTE`-1: `rd`=0, `wr`=1, `adr_wr`=idx, `dout`=latch.
    - At the end of the slot `idx` increments. After `idx`=`OAM_BYTES`-1 the state goes to IDLE.
- No source remapping: src E0–FF is emitted verbatim, and the memory map decides what responds.
- `idx` is 8-bit and never exceeds `OAM_BYTES`-1, so no wrap-around.
- `write_reg` takes priority over slot advance in the same cycle: the in-flight byte is abandoned and `wr` for it is not issued after the restart.
- Asynchronous reset mid-transfer returns to IDLE immediately. OAM keeps any partially written bytes.

## Timing
- Write edge at cycle T:
  - `active`=1 from T+1.
  - First `rd` at T+1+`CYCLES_PER_BYTE`.
  - First `wr` at T+`2*CYCLES_PER_BYTE`.
- Last `wr` at T+`CYCLES_PER_BYTE`*(`OAM_BYTES`+1). `active` falls on the following cycle.
- Total active duration: `CYCLES_PER_BYTE`*(`OAM_BYTES`+1) cycles (644 at defaults).
- `dout_reg` updates on the write edge and is readable on the next cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from `din` or `write_reg` to any output.

## Structure
- The shared constants header holds `OAM_BYTES`, the FF46 I/O offset (8'h46) and the OAM base (16'hFE00); `gb_iomap` uses the same FF46 constant.
- State encoding (IDLE/START/XFER) is a local localparam.
- Sub-module `lr35902_dma_slot`: the phase counter producing `rd_phase`, `latch_en`, `wr_phase` and `slot_end`, reusable for other M-cycle-paced engines.

## Test plan
- **Basic copy:** preload source C000–C09F with 8'h00..8'h9F, write 8'hC0 → OAM[i]=i for all 160 entries; `active` high for exactly 644 cycles; `dout_reg`=8'hC0.
- **Restart mid-transfer:** write 8'hC0, then at idx=50 write 8'hD0 (source D000.. = 8'hFF) → `idx` restarts at 0; all 160 OAM bytes end at 8'hFF; `active` stays high continuously for 644 cycles after the second write.
- **Async reset:** pull `n_reset` low during idx=80 → `active`, `rd`, `wr` are 0 combinationally; OAM[0..79] hold copied data; `dout_reg`=8'h00.
- **Strobe timing:** with `CYCLES_PER_BYTE`=4 → in every slot `rd` is high 3 cycles, then `wr` is high 1 cycle; `rd` and `wr` are never high together; `adr_wr` equals `adr_rd[7:0]` of the preceding read.
- **Edge source:** write 8'hFE → `adr_rd` runs FE00..FE9F unmodified; `active` duration unchanged.
- **Parameter sweep:** `CYCLES_PER_BYTE`=2 → transfer completes in 322 cycles with correct data.

Source files
------------

// File: rtl/lr35902_dma_pkg.sv
// Shared constants and types for the LR35902 OAM DMA engine and its I/O decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lr35902_dma_pkg;

  // Bytes copied per OAM DMA transfer (FE00..FE9F).
  localparam int DMA_OAM_BYTES = 160;

  // Low byte of the FF46 DMA source register; the I/O decoder uses the same constant.
  localparam logic [7:0] IO_DMA_OFS = 8'h46;

  // Base address of object attribute memory.
  localparam logic [15:0] OAM_BASE = 16'hFE00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } dma_state_t;

  // Full CPU-visible OAM address for a byte index.
  function automatic logic [15:0] oam_addr(input logic [7:0] idx);
    return OAM_BASE | {8'h00, idx};
  endfunction

endpackage

// File: rtl/lr35902_dma_if.sv
// Bus bundle between the OAM DMA engine and the memory map / OAM / FF46 register port.
// Latency: n/a (wires only).
// Backpressure: none; the memory map answers reads combinationally and OAM always accepts writes.
//   master: DMA side. Drives dout_reg, adr_rd, rd, adr_wr, wr, dout, active.
//   slave : system side. Drives din_reg, write_reg (FF46 write), din (source read data).
interface lr35902_dma_if;
  logic [7:0]  din_reg;
  logic        write_reg;
  logic [7:0]  dout_reg;
  logic [15:0] adr_rd;
  logic        rd;
  logic [7:0]  din;
  logic [7:0]  adr_wr;
  logic        wr;
  logic [7:0]  dout;
  logic        active;

  modport master (
    input  din_reg, write_reg, din,
    output dout_reg, adr_rd, rd, adr_wr, wr, dout, active
  );

  modport slave (
    output din_reg, write_reg, din,
    input  dout_reg, adr_rd, rd, adr_wr, wr, dout, active
  );
endinterface

// File: rtl/lr35902_dma_slot.sv
// M-cycle slot pacer: phase counter 0..CYCLES-1 with read/latch/write phase decodes.
// Latency: decodes come straight from the registered phase; clr takes effect at the next edge.
// Backpressure: none; counts every cycle while en is high, clr wins over en.
//   clr      : restart the slot at phase 0
//   en       : advance the phase
//   rd_phase : phases 0..CYCLES-2 (source read window)
//   latch_en : phase CYCLES-2 (last read cycle, capture data at its closing edge)
//   wr_phase : phase CYCLES-1 (write cycle)
//   slot_end : last phase of a running slot
module lr35902_dma_slot #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  input  logic en,
  output logic rd_phase,
  output logic latch_en,
  output logic wr_phase,
  output logic slot_end
);

  localparam int PW = $clog2(CYCLES);
  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES - 1);
  localparam logic [PW-1:0] PH_LATCH = PW'(CYCLES - 2);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign rd_phase = (phase_q != PH_LAST);
  assign latch_en = (phase_q == PH_LATCH);
  assign wr_phase = (phase_q == PH_LAST);
  assign slot_end = en && (phase_q == PH_LAST);

endmodule

// File: rtl/lr35902_dma.sv
// OAM DMA: FF46 source register plus the 160-byte copy {src,00}.. -> OAM, one byte per M-cycle.
// Latency: active 1 cycle after the FF46 write, first wr 2*CYCLES_PER_BYTE cycles after it.
// Backpressure: none; a new FF46 write restarts the copy at once and drops the byte in flight.
//   clk, n_reset : core clock, async active-low reset
//   bus (master) : FF46 write/readback, source read port, OAM write port, active flag
module lr35902_dma
  import lr35902_dma_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int OAM_BYTES       = DMA_OAM_BYTES
) (
  input  logic               clk,
  input  logic               n_reset,
  lr35902_dma_if.master      bus
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

  dma_state_t state_q, state_d;
  logic [7:0] src_q,   src_d;
  logic [7:0] idx_q,   idx_d;
  logic [7:0] latch_q, latch_d;

  logic rd_phase;
  logic latch_en;
  logic wr_phase;
  logic slot_end;

  // The setup slot in START uses the same pacer as the copy slots, so the
  // phase counter simply keeps running across the START->XFER boundary.
  lr35902_dma_slot #(
    .CYCLES (CYCLES_PER_BYTE)
  ) u_slot (
    .clk      (clk),
    .n_reset  (n_reset),
    .clr      (bus.write_reg),
    .en       (state_q != ST_IDLE),
    .rd_phase (rd_phase),
    .latch_en (latch_en),
    .wr_phase (wr_phase),
    .slot_end (slot_end)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    if (bus.write_reg) begin
      // Restart from any state; slot advance in this cycle is ignored.
      src_d   = bus.din_reg;
      idx_d   = '0;
      state_d = ST_START;
    end else begin
      case (state_q)
        ST_START: begin
          if (slot_end) begin
            state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          if (latch_en) begin
            latch_d = bus.din;
          end
          if (slot_end) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      idx_q   <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
    end
  end

  // Outputs are pure decodes of registered state: nothing from din or
  // write_reg reaches a port in the same cycle.
  assign bus.dout_reg = src_q;
  assign bus.active   = (state_q != ST_IDLE);
  assign bus.rd       = (state_q == ST_XFER) && rd_phase;
  assign bus.wr       = (state_q == ST_XFER) && wr_phase;
  assign bus.adr_rd   = {src_q, idx_q};
  assign bus.adr_wr   = idx_q;
  assign bus.dout     = latch_q;

endmodule
